alu_decode: RTL and testbench
=============================

# alu_decode

Decode stage that produces the operand/function interface consumed by the execute ALU. Accepts one 32-bit RV64I instruction per handshake from fetch, reads register operands via combinational register-file address outputs, and extracts immediates. Registers `opr_a_o`/`opr_b_o`/`alu_func_o` plus writeback control into a valid/ready pipeline slot feeding execute. Covers the OP, OP-IMM, LUI and AUIPC opcodes; everything else is flagged illegal.

## Interface
- No parameters. `alu_func_o` encodings come from `cpu_consts`: OP_ADD=0, OP_SUB=1, OP_SLL=2, OP_SRL=3, OP_SRA=4, OP_OR=5, OP_AND=6, OP_XOR=7, OP_SLTU=8, OP_SLT=9.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `instr_valid_i`  in  1  fetch has an instruction.
- `instr_ready_o`  out  1  decode accepts this cycle.
- `instr_i`  in  32  instruction word.
- `pc_i`  in  64  PC of `instr_i`.
- `rs1_addr_o`, `rs2_addr_o`  out  5 each  `instr_i[19:15]`, `instr_i[24:20]`; combinational.
- `rs1_data_i`, `rs2_data_i`  in  64 each  register-file read data, valid in the same cycle.
- `flush_i`  in  1  discard the held and incoming instruction.
- `ex_valid_o`  out  1  output slot valid.
- `ex_ready_i`  in  1  execute consumes the slot.
- `opr_a_o`, `opr_b_o`  out  64 each  ALU operands.
- `alu_func_o`  out  4  ALU function.
- `rd_addr_o`  out  5  destination register.
- `rd_we_o`  out  1  write-back enable.
- `illegal_o`  out  1  unsupported encoding.

## Operation
- Accept when `instr_valid_i && instr_ready_o && !flush_i`.
- OP (0110011): a=rs1, b=rs2. funct7=0000000 selects by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND. funct7=0100000 is valid only with funct3 000 (SUB) or 101 (SRA). Any other funct7 is illegal.
- OP-IMM (0010011): a=rs1, b=sext(instr[31:20]). funct3 selects as for OP, except that 000 is always ADD.
  - funct3 001 requires instr[31:26]=000000; b = {58'b0, instr[25:20]}.
  - funct3 101: instr[31:26]=000000 gives SRL, 010000 gives SRA, with the same b. Other values are illegal.
- LUI (0110111): a=0, b=sext({instr[31:12],12'b0}), ADD.
- AUIPC (0010111): a=`pc_i`, b as LUI, ADD.
- `rd_addr_o` = instr[11:7]. `rd_we_o`=1 for legal instructions.
- Illegal instruction: slot still issues with `illegal_o`=1, `rd_we_o`=0, a=b=0, OP_ADD.
- All 64-bit arithmetic is sign extension from bit 31 of the instruction. No truncation.

## Timing
- Reset: `ex_valid_o`=0; `opr_a_o`, `opr_b_o`, `alu_func_o`, `rd_addr_o`, `rd_we_o`, `illegal_o` all 0. `instr_ready_o` is 1 when `resetn` is high (without `ALU_DECODE_SKID_EN`), 1 with `ALU_DECODE_SKID_EN` (skid empty).
- Latency: an instruction accepted in cycle N is presented on the outputs in N+1.
- Output slot fields are stable while `ex_valid_o && !ex_ready_i`.
- Without skid: `instr_ready_o = !ex_valid_o || ex_ready_i` (combinational). Accept and drain in the same cycle gives full throughput.
- `flush_i` beats everything: the next cycle has `ex_valid_o`=0 and the skid is empty. An instruction presented in the flush cycle is dropped, and fetch sees `instr_ready_o` deasserted.
- Reset asserted mid-operation clears the slot immediately (asynchronously).

## Configuration
- `ALU_DECODE_SKID_EN` defined:
  - Adds a one-entry skid register, and `instr_ready_o` = !skid_full, taken from a flop.
  - An instruction accepted while the slot is stalled goes into the skid. The skid moves into the slot on the next `ex_ready_i`.
  - Order is preserved and throughput stays at 1/cycle.
- Not defined: no skid, and the combinational ready rule from Timing applies.

## Test plan
- `ADD x3,x1,x2` (0x002081B3), rs1=5, rs2=7 -> next cycle `ex_valid_o`=1, a=5, b=7, OP_ADD, rd=3, we=1. `rs1_addr_o`=1 and `rs2_addr_o`=2 in the accept cycle.
- `ADDI x1,x0,-1` (0xFFF00093), rs1=0 -> a=0, b=0xFFFFFFFFFFFFFFFF, OP_ADD.
- `SRAI x2,x1,33` (0x4210D113) -> b=33, OP_SRA. Setting instr[31:26]=110000 instead -> `illegal_o`=1, we=0.
- `LUI x5,0x80000` (0x800002B7) -> a=0, b=0xFFFFFFFF80000000. `AUIPC` with pc=0x1000 and imm 0x1 -> a=0x1000, b=0x1000.
- Backpressure: `ex_ready_i`=0 for 3 cycles with `instr_valid_i`=1.
  - Outputs held constant.
  - Without skid: `instr_ready_o`=0.
  - With skid: exactly one extra accepted, then ready=0. Order is preserved on release.
- `flush_i` pulsed while the slot is valid and a new instruction is presented -> `ex_valid_o`=0 next cycle. The dropped instruction never appears.

Source files
------------

// File: rtl/alu_decode.sv
// RV64I decode stage for OP / OP-IMM / LUI / AUIPC feeding a valid/ready slot to execute.
// Optional one-entry skid buffer enabled by defining ALU_DECODE_SKID_EN.
package cpu_consts;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_SRA  = 4'd4,
        OP_OR   = 4'd5,
        OP_AND  = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLTU = 4'd8,
        OP_SLT  = 4'd9
    } alu_op_e;
endpackage

module alu_decode
    import cpu_consts::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic [63:0] pc_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [63:0] rs1_data_i,
    input  logic [63:0] rs2_data_i,
    input  logic        flush_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [63:0] opr_a_o,
    output logic [63:0] opr_b_o,
    output logic [3:0]  alu_func_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        illegal_o
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [63:0] opr_a;
        logic [63:0] opr_b;
        alu_op_e     func;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } slot_t;

    slot_t       dec_d;
    slot_t       slot_q;
    logic        ex_valid_q;
    logic        accept;
    logic        bad;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm_i;
    logic [63:0] imm_u;
    logic [63:0] shamt;
    alu_op_e     f3_op;

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];
    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign imm_i      = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_u      = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
    assign shamt      = {58'b0, instr_i[25:20]};

    always_comb begin
        case (funct3)
            3'b000:  f3_op = OP_ADD;
            3'b001:  f3_op = OP_SLL;
            3'b010:  f3_op = OP_SLT;
            3'b011:  f3_op = OP_SLTU;
            3'b100:  f3_op = OP_XOR;
            3'b101:  f3_op = OP_SRL;
            3'b110:  f3_op = OP_OR;
            default: f3_op = OP_AND;
        endcase
    end

    // NOTE: every field gets a default before the case so no path can infer a latch.
    always_comb begin
        dec_d      = '0;
        dec_d.rd   = instr_i[11:7];
        dec_d.func = OP_ADD;
        bad        = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_d.opr_a = rs1_data_i;
                dec_d.opr_b = rs2_data_i;
                if (funct7 == 7'b0000000)                          dec_d.func = f3_op;
                else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec_d.func = OP_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec_d.func = OP_SRA;
                else                                               bad = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_d.opr_a = rs1_data_i;
                dec_d.opr_b = imm_i;
                dec_d.func  = f3_op;
                // RV64 shifts carry a 6-bit shamt; the upper six bits pick logical vs arithmetic.
                if (funct3 == 3'b001) begin
                    dec_d.opr_b = shamt;
                    if (instr_i[31:26] != 6'b000000) bad = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec_d.opr_b = shamt;
                    if (instr_i[31:26] == 6'b000000)      dec_d.func = OP_SRL;
                    else if (instr_i[31:26] == 6'b010000) dec_d.func = OP_SRA;
                    else                                  bad = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_d.opr_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_d.opr_a = pc_i;
                dec_d.opr_b = imm_u;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec_d.opr_a   = '0;
            dec_d.opr_b   = '0;
            dec_d.func    = OP_ADD;
            dec_d.illegal = 1'b1;
        end else begin
            dec_d.we = 1'b1;
        end
    end

`ifdef ALU_DECODE_SKID_EN
    logic  skid_full_q;
    slot_t skid_q;

    assign instr_ready_o = !skid_full_q && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid_q  <= 1'b0;
            slot_q      <= '0;
            skid_full_q <= 1'b0;
        end else if (flush_i) begin
            ex_valid_q  <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (!ex_valid_q || ex_ready_i) begin
            if (skid_full_q) begin
                slot_q      <= skid_q;
                ex_valid_q  <= 1'b1;
                skid_full_q <= 1'b0;
            end else if (accept) begin
                slot_q     <= dec_d;
                ex_valid_q <= 1'b1;
            end else begin
                ex_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_full_q <= 1'b1;
        end
    end

    // NOTE: skid payload needs no reset; skid_full_q alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (accept && ex_valid_q && !ex_ready_i) skid_q <= dec_d;
    end
`else
    assign instr_ready_o = (!ex_valid_q || ex_ready_i) && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o && !flush_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid_q <= 1'b0;
            slot_q     <= '0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            slot_q     <= dec_d;
            ex_valid_q <= 1'b1;
        end else if (ex_ready_i) begin
            ex_valid_q <= 1'b0;
        end
    end
`endif

    assign ex_valid_o = ex_valid_q;
    assign opr_a_o    = slot_q.opr_a;
    assign opr_b_o    = slot_q.opr_b;
    assign alu_func_o = slot_q.func;
    assign rd_addr_o  = slot_q.rd;
    assign rd_we_o    = slot_q.we;
    assign illegal_o  = slot_q.illegal;
endmodule

// File: tb/tb_alu_decode.sv
// Directed self-checking bench for alu_decode; expectations follow ALU_DECODE_SKID_EN if defined.
module tb_alu_decode;
    logic        clk = 1'b0;
    logic        resetn;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [63:0] pc_i;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [63:0] rs1_data_i;
    logic [63:0] rs2_data_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [63:0] opr_a_o;
    logic [63:0] opr_b_o;
    logic [3:0]  alu_func_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;
    logic        illegal_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_decode dut (
        .clk           (clk),
        .resetn        (resetn),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .rs1_addr_o    (rs1_addr_o),
        .rs2_addr_o    (rs2_addr_o),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .flush_i       (flush_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .opr_a_o       (opr_a_o),
        .opr_b_o       (opr_b_o),
        .alu_func_o    (alu_func_o),
        .rd_addr_o     (rd_addr_o),
        .rd_we_o       (rd_we_o),
        .illegal_o     (illegal_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] func, input logic [4:0] rd,
                              input logic we, input logic ill);
        check({tag, ".valid"}, 64'(ex_valid_o), 64'd1);
        check({tag, ".a"},     opr_a_o, a);
        check({tag, ".b"},     opr_b_o, b);
        check({tag, ".func"},  64'(alu_func_o), 64'(func));
        check({tag, ".rd"},    64'(rd_addr_o), 64'(rd));
        check({tag, ".we"},    64'(rd_we_o), 64'(we));
        check({tag, ".ill"},   64'(illegal_o), 64'(ill));
    endtask

    // Present one instruction with execute ready, then step to the cycle it should appear.
    task automatic issue(input logic [31:0] ins, input logic [63:0] pc,
                         input logic [63:0] r1, input logic [63:0] r2);
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        pc_i          = pc;
        rs1_data_i    = r1;
        rs2_data_i    = r2;
        ex_ready_i    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn        = 1'b0;
        instr_valid_i = 1'b0;
        instr_i       = '0;
        pc_i          = '0;
        rs1_data_i    = '0;
        rs2_data_i    = '0;
        flush_i       = 1'b0;
        ex_ready_i    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 64'(ex_valid_o), 64'd0);
        check("rst.a",     opr_a_o, 64'd0);
        check("rst.b",     opr_b_o, 64'd0);
        check("rst.func",  64'(alu_func_o), 64'd0);
        check("rst.rd",    64'(rd_addr_o), 64'd0);
        check("rst.we",    64'(rd_we_o), 64'd0);
        check("rst.ill",   64'(illegal_o), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst.ready", 64'(instr_ready_o), 64'd1);

        // ADD x3,x1,x2 with register addresses visible in the accept cycle
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_i       = 32'h002081B3;
        rs1_data_i    = 64'd5;
        rs2_data_i    = 64'd7;
        #1;
        check("add.rs1addr", 64'(rs1_addr_o), 64'd1);
        check("add.rs2addr", 64'(rs2_addr_o), 64'd2);
        check("add.ready",   64'(instr_ready_o), 64'd1);
        @(posedge clk);
        #1;
        check_slot("add", 64'd5, 64'd7, 4'd0, 5'd3, 1'b1, 1'b0);

        issue(32'h40208233, 64'd0, 64'd10, 64'd3);
        check_slot("sub", 64'd10, 64'd3, 4'd1, 5'd4, 1'b1, 1'b0);
        issue(32'hFFF00093, 64'd0, 64'd0, 64'd0);
        check_slot("addi", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 5'd1, 1'b1, 1'b0);
        issue(32'h4210D113, 64'd0, 64'h123, 64'd0);
        check_slot("srai", 64'h123, 64'd33, 4'd4, 5'd2, 1'b1, 1'b0);
        issue(32'hC210D113, 64'd0, 64'h123, 64'd0);
        check_slot("srai_bad", 64'd0, 64'd0, 4'd0, 5'd2, 1'b0, 1'b1);
        // SLLI x2,x1,63: shamt taken unsigned from instr[25:20]
        issue(32'h03F09113, 64'd0, 64'h55, 64'd0);
        check_slot("slli", 64'h55, 64'd63, 4'd2, 5'd2, 1'b1, 1'b0);
        // SLTIU x9,x1,-2: immediate sign-extended
        issue(32'hFFE0B493, 64'd0, 64'd4, 64'd0);
        check_slot("sltiu", 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 4'd8, 5'd9, 1'b1, 1'b0);
        // funct7=0000001 (M extension) is not supported
        issue(32'h022081B3, 64'd0, 64'd5, 64'd7);
        check_slot("op_f7bad", 64'd0, 64'd0, 4'd0, 5'd3, 1'b0, 1'b1);
        issue(32'h800002B7, 64'd0, 64'd9, 64'd9);
        check_slot("lui", 64'd0, 64'hFFFF_FFFF_8000_0000, 4'd0, 5'd5, 1'b1, 1'b0);
        issue(32'h00001317, 64'h1000, 64'd0, 64'd0);
        check_slot("auipc", 64'h1000, 64'h1000, 4'd0, 5'd6, 1'b1, 1'b0);
        // Unsupported opcode (LOAD)
        issue(32'h0000B183, 64'd0, 64'd1, 64'd1);
        check_slot("load_bad", 64'd0, 64'd0, 4'd0, 5'd3, 1'b0, 1'b1);

        // Drain, then backpressure: A held in the slot while B waits
        @(negedge clk);
        instr_valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("drain.valid", 64'(ex_valid_o), 64'd0);
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_i       = 32'h00100393;
        rs1_data_i    = 64'd0;
        ex_ready_i    = 1'b0;
        @(posedge clk);
        #1;
        check_slot("bp.A", 64'd0, 64'd1, 4'd0, 5'd7, 1'b1, 1'b0);
        @(negedge clk);
        instr_i = 32'h00200413;
        for (int i = 0; i < 3; i++) begin
            #1;
`ifdef ALU_DECODE_SKID_EN
            check($sformatf("bp.ready%0d", i), 64'(instr_ready_o), (i == 0) ? 64'd1 : 64'd0);
`else
            check($sformatf("bp.ready%0d", i), 64'(instr_ready_o), 64'd0);
`endif
            @(posedge clk);
            #1;
            check_slot($sformatf("bp.hold%0d", i), 64'd0, 64'd1, 4'd0, 5'd7, 1'b1, 1'b0);
            @(negedge clk);
        end
        ex_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check_slot("bp.B", 64'd0, 64'd2, 4'd0, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        instr_valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("bp.after", 64'(ex_valid_o), 64'd0);

        // Flush while the slot holds C and D is presented
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_i       = 32'h002081B3;
        rs1_data_i    = 64'd5;
        rs2_data_i    = 64'd7;
        ex_ready_i    = 1'b0;
        @(posedge clk);
        #1;
        check("fl.C", 64'(ex_valid_o), 64'd1);
        @(negedge clk);
        instr_i = 32'h800002B7;
        flush_i = 1'b1;
        #1;
        check("fl.ready", 64'(instr_ready_o), 64'd0);
        @(posedge clk);
        #1;
        check("fl.valid", 64'(ex_valid_o), 64'd0);
        @(negedge clk);
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        ex_ready_i    = 1'b1;
        @(posedge clk);
        #1;
        check("fl.dropped", 64'(ex_valid_o), 64'd0);

        // Asynchronous reset in mid-cycle clears a valid slot at once
        issue(32'h002081B3, 64'd0, 64'd5, 64'd7);
        check("ar.pre", 64'(ex_valid_o), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("ar.valid", 64'(ex_valid_o), 64'd0);
        check("ar.a",     opr_a_o, 64'd0);
        check("ar.we",    64'(rd_we_o), 64'd0);
        @(negedge clk);
        instr_valid_i = 1'b0;
        resetn        = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
